// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches, buffers
// returned words and hands {instr, instr_pc} to the decoder; redirects flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW:0]   C_DEPTH = (CW+1)'(BUF_DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outst, r_drop, r_cnt;
  logic [31:0]   r_fifo_pc   [BUF_DEPTH];
  logic [31:0]   r_fifo_word [BUF_DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [31:0]   r_rq_pc     [BUF_DEPTH];
  logic [PW-1:0] r_rq_rd, r_rq_wr;

  logic [CW:0]   w_inflight;
  logic          w_req_fire, w_push, w_pop;

  // Issue cap counts dropped-but-outstanding fetches too, so the FIFO can never overflow.
  assign w_inflight     = {1'b0, r_outst} + {1'b0, r_cnt};
  assign imem_req_valid = !reset && !redirect_valid && (w_inflight < C_DEPTH);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_push      = imem_rsp_valid && !redirect_valid && (r_drop == '0);
  assign instr_valid = (r_cnt != '0);
  assign w_pop       = instr_valid && instr_ready && !redirect_valid;
  assign instr       = instr_valid ? r_fifo_word[r_rd] : '0;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_rd]   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_outst <= '0;
      r_drop  <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_rq_rd <= '0;
      r_rq_wr <= '0;
    end else begin
      r_outst <= r_outst + (w_req_fire ? C_ONE : '0) - (imem_rsp_valid ? C_ONE : '0);
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_pc    <= {redirect_pc[31:2], 2'b00};
        r_drop  <= r_outst - (imem_rsp_valid ? C_ONE : '0);
        r_cnt   <= '0;
        r_rd    <= '0;
        r_wr    <= '0;
        r_rq_rd <= '0;
        r_rq_wr <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc    <= r_pc + 32'd4;
          r_rq_wr <= r_rq_wr + P_ONE;
        end
        if (imem_rsp_valid && (r_drop != '0))
          r_drop <= r_drop - C_ONE;
        if (w_push) begin
          r_wr    <= r_wr + P_ONE;
          r_rq_rd <= r_rq_rd + P_ONE;
        end
        if (w_pop)
          r_rd <= r_rd + P_ONE;
        r_cnt <= r_cnt + (w_push ? C_ONE : '0) - (w_pop ? C_ONE : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire)
      r_rq_pc[r_rq_wr] <= r_pc;
    if (w_push) begin
      r_fifo_pc[r_wr]   <= r_rq_pc[r_rq_rd];
      r_fifo_word[r_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model plus in-order memory model,
// compared every cycle, with directed phases pinned by literal expectations.
module tb_fetch_unit;
  localparam int          D   = 2;
  localparam logic [31:0] RPC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, instr_pc;
  logic        redirect_valid, instr_valid, instr_ready;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  typedef struct { logic [31:0] a; int due; } mreq_t;

  ent_t        fifo[$];
  logic [31:0] rq[$];
  mreq_t       mem[$];
  logic [31:0] m_pc;
  int          m_outst, m_drop, cyc;
  bit          m_valid;

  int  n_cmp, n_bad;
  int  k_ir = 100, k_mrdy = 100, k_lat = 0, k_redir = 0;
  bit  f_reset, f_redir, f_rcond;
  logic [31:0] f_rpc;

  logic        s_rv, s_iv, e_rv, e_iv, rsp;
  logic [31:0] s_addr, s_ipc, s_instr, e_ipc, e_in;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C3C_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    ent_t e;
    bit   req;
    reset = f_reset;
    rsp   = !f_reset && mem.size() > 0 && mem[0].due <= cyc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mdata(mem[0].a) : $urandom;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (!f_reset && (f_redir || (f_rcond && rsp && fifo.size() > 0))) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_rpc;
      f_redir = 0;
      f_rcond = 0;
    end else if (!f_reset && ($urandom_range(99) < k_redir)) begin
      redirect_valid = 1'b1;
    end
    instr_ready    = ($urandom_range(99) < k_ir);
    imem_req_ready = ($urandom_range(99) < k_mrdy);

    e_rv  = !reset && !redirect_valid && (m_outst + fifo.size() < D);
    e_iv  = fifo.size() != 0;
    e_ipc = e_iv ? fifo[0].pc : 32'h0;
    e_in  = e_iv ? fifo[0].w  : 32'h0;

    @(negedge clk);
    s_rv = imem_req_valid; s_addr = imem_req_addr;
    s_iv = instr_valid; s_ipc = instr_pc; s_instr = instr;
    if (m_valid) begin
      chk("req_valid", s_rv, e_rv);
      if (e_rv) chk("req_addr", s_addr, m_pc);
      chk("instr_valid", s_iv, e_iv);
      chk("instr_pc", s_ipc, e_ipc);
      chk("instr", s_instr, e_in);
    end

    @(posedge clk);
    if (reset) begin
      m_pc = RPC; m_outst = 0; m_drop = 0; m_valid = 1;
      fifo.delete(); rq.delete(); mem.delete();
    end else begin
      req = e_rv && imem_req_ready;
      if (rsp) begin
        void'(mem.pop_front());
        m_outst--;
      end
      if (redirect_valid) begin
        m_drop = m_outst;
        m_pc   = {redirect_pc[31:2], 2'b00};
        fifo.delete(); rq.delete();
      end else begin
        if (e_iv && instr_ready) void'(fifo.pop_front());
        if (rsp) begin
          if (m_drop > 0) m_drop--;
          else begin
            e.pc = rq.pop_front();
            e.w  = imem_rsp_data;
            fifo.push_back(e);
          end
        end
        if (req) begin
          rq.push_back(m_pc);
          mem.push_back('{m_pc, cyc + 1 + $urandom_range(k_lat, 0)});
          m_outst++;
          m_pc += 32'd4;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic wait_rv(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!s_rv && n < 60);
    chk(nm, s_rv, 1'b1);
  endtask

  task automatic wait_iv(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!s_iv && n < 60);
    chk(nm, s_iv, 1'b1);
  endtask

  initial begin
    int n;
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    f_reset = 1; f_redir = 0; f_rcond = 0; f_rpc = '0;
    n_cmp = 0; n_bad = 0; cyc = 0; m_valid = 0;
    #1;
    repeat (3) tick();
    f_reset = 0;

    // Startup with 1-cycle memory and an always-ready decoder
    tick();
    chk("c1_rv", s_rv, 1'b1); chk("c1_addr", s_addr, 32'h0100_0000); chk("c1_iv", s_iv, 1'b0);
    tick();
    chk("c2_addr", s_addr, 32'h0100_0004); chk("c2_iv", s_iv, 1'b0);
    tick();
    chk("c3_iv", s_iv, 1'b1); chk("c3_ipc", s_ipc, 32'h0100_0000);
    chk("c3_instr", s_instr, mdata(32'h0100_0000)); chk("c3_rv_cap", s_rv, 1'b0);
    tick();
    chk("c4_ipc", s_ipc, 32'h0100_0004); chk("c4_addr", s_addr, 32'h0100_0008);

    // Decoder stall fills the buffer and stops issue
    k_ir = 0;
    repeat (6) tick();
    chk("stall_rv", s_rv, 1'b0); chk("stall_iv", s_iv, 1'b1);
    chk("stall_ipc", s_ipc, 32'h0100_0008);
    k_ir = 100;
    repeat (6) tick();

    // Redirect with two fetches still in flight
    k_lat = 4; n = 0;
    do begin tick(); n++; end while (m_outst != 2 && n < 60);
    chk("outst2_reached", m_outst, 2);
    f_redir = 1; f_rpc = 32'h0000_0103;
    tick();
    tick();
    chk("redir_flush_iv", s_iv, 1'b0);
    if (!s_rv) wait_rv("redir_rv_timeout");
    chk("redir_addr", s_addr, 32'h0000_0100);
    if (!s_iv) wait_iv("redir_iv_timeout");
    chk("redir_first_pc", s_ipc, 32'h0000_0100);

    // Redirect coinciding with a response and a decoder pop
    k_lat = 0; f_rpc = 32'h0000_2000; f_rcond = 1; n = 0;
    do begin tick(); n++; end while (f_rcond && n < 60);
    chk("coincide_fired", f_rcond, 1'b0);
    tick();
    chk("coincide_iv", s_iv, 1'b0);
    if (!s_rv) wait_rv("coincide_rv_timeout");
    chk("coincide_addr", s_addr, 32'h0000_2000);
    repeat (8) tick();

    // PC wraparound; low target bits are ignored
    f_redir = 1; f_rpc = 32'hFFFF_FFFE;
    tick();
    wait_rv("wrap_rv1");
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    wait_rv("wrap_rv2");
    chk("wrap_addr1", s_addr, 32'h0000_0000);
    repeat (6) tick();

    // Reset mid-stream with fetches outstanding
    k_lat = 2; n = 0;
    do begin tick(); n++; end while (m_outst == 0 && n < 60);
    chk("mid_outst", (m_outst > 0), 1'b1);
    f_reset = 1;
    tick();
    tick();
    chk("rst_iv", s_iv, 1'b0); chk("rst_rv", s_rv, 1'b0);
    f_reset = 0;
    tick();
    chk("rst_restart_rv", s_rv, 1'b1); chk("rst_restart_addr", s_addr, RPC);

    // Randomized traffic
    k_ir = 70; k_mrdy = 70; k_lat = 3; k_redir = 3;
    for (int i = 0; i < 3000; i++) begin
      f_reset = (i % 700 == 699);
      if (i % 250 == 100) begin k_ir = $urandom_range(100); k_mrdy = $urandom_range(20, 100); end
      tick();
    end
    f_reset = 0; k_redir = 0; k_ir = 100;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
